// File: rtl/rx_iq_frame_tx_if.sv
// rx_iq_frame_tx_if: sample input and serial/status output bundle for rx_iq_frame_tx
interface rx_iq_frame_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                                 in_strobe;
    logic signed [23:0]                   in_real;
    logic signed [23:0]                   in_imag;
    logic [7:0]                           rx_rate;
    logic                                 flag_clear;
    logic                                 ser_bclk;
    logic                                 ser_fs;
    logic                                 ser_data;
    logic [$clog2(FIFO_DEPTH + 1) - 1:0]  fifo_level;
    logic                                 overflow;
    logic                                 underrun;

    modport master (
        output in_strobe, in_real, in_imag, rx_rate, flag_clear,
        input  ser_bclk, ser_fs, ser_data, fifo_level, overflow, underrun
    );
    modport slave (
        input  in_strobe, in_real, in_imag, rx_rate, flag_clear,
        output ser_bclk, ser_fs, ser_data, fifo_level, overflow, underrun
    );
endinterface

// File: rtl/rx_iq_frame_tx.sv
// rx_iq_frame_tx: FIFO-buffered serialiser of 24-bit I/Q pairs into free-running DSP-mode frames
module rx_iq_frame_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_BITS = 50
) (
    input  logic            clock,
    input  logic            reset,
    rx_iq_frame_tx_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(FRAME_BITS);

    logic [4:0]    cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          fast_q, fast_d;
    logic [47:0]   sr_q, sr_d;
    logic [47:0]   mem_q [FIFO_DEPTH];
    logic [47:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          bclk_q, bclk_d, fs_q, fs_d, data_q, data_d;
    logic          ovf_q, ovf_d, und_q, und_d;
    logic          wrap, start, payload, empty, full, pop, push;

    // bit_q holds the index of the bit emitted at the next wrap, so the reset value 0 makes the first wrap a frame start
    assign wrap    = cnt_q == (fast_q ? 5'd15 : 5'd31);
    assign start   = wrap && bit_q == '0;
    assign payload = bit_q != '0 && bit_q <= BW'(48);
    assign empty   = lvl_q == '0;
    assign full    = lvl_q == LW'(FIFO_DEPTH);
    assign pop     = start && !empty;
    assign push    = bus.in_strobe && (!full || pop);

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = {bus.in_real, bus.in_imag};
        cnt_d  = wrap ? '0 : cnt_q + 5'd1;
        bit_d  = !wrap ? bit_q : (bit_q == BW'(FRAME_BITS - 1)) ? '0 : bit_q + 1'b1;
        fast_d = start ? bus.rx_rate == 8'd1 : fast_q;
        bclk_d = wrap ? 1'b1 : (cnt_q == (fast_q ? 5'd7 : 5'd15)) ? 1'b0 : bclk_q;
        fs_d   = wrap ? start : fs_q;
        data_d = wrap ? payload && sr_q[47] : data_q;
        sr_d   = start ? (empty ? '0 : mem_q[rd_q]) : (wrap && payload) ? {sr_q[46:0], 1'b0} : sr_q;
        wr_d   = push ? wr_q + 1'b1 : wr_q;
        rd_d   = pop ? rd_q + 1'b1 : rd_q;
        lvl_d  = lvl_q + LW'(push) - LW'(pop);
        ovf_d  = (bus.in_strobe && full && !pop) || (ovf_q && !bus.flag_clear);
        und_d  = (start && empty) || (und_q && !bus.flag_clear);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= 5'd31;
            bit_q  <= '0;
            fast_q <= 1'b0;
            sr_q   <= '0;
            mem_q  <= '{default: '0};
            wr_q   <= '0;
            rd_q   <= '0;
            lvl_q  <= '0;
            bclk_q <= 1'b0;
            fs_q   <= 1'b0;
            data_q <= 1'b0;
            ovf_q  <= 1'b0;
            und_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            fast_q <= fast_d;
            sr_q   <= sr_d;
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            lvl_q  <= lvl_d;
            bclk_q <= bclk_d;
            fs_q   <= fs_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
            und_q  <= und_d;
        end
    end

    assign bus.ser_bclk   = bclk_q;
    assign bus.ser_fs     = fs_q;
    assign bus.ser_data   = data_q;
    assign bus.fifo_level = lvl_q;
    assign bus.overflow   = ovf_q;
    assign bus.underrun   = und_q;
endmodule
